// File: rtl/res_collector.sv
// rtl/res_collector.sv - packs a valid-qualified result stream into NUM-item packets behind a valid/ready handshake
// Optional per-packet 16-bit checksum on pkt_sum_o when RES_CHECKSUM_EN is defined.
module res_collector #(
  parameter int NUM        = 100,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_W      = $clog2(NUM + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      res_valid_i,
  input  logic [ITEM_WIDTH-1:0]     res_i,
  output logic [NUM*ITEM_WIDTH-1:0] pkt_o,
  output logic                      pkt_valid_o,
  input  logic                      pkt_ready_i,
  output logic [CNT_W-1:0]          fill_o,
  output logic [31:0]               pkt_cnt_o,
  output logic                      overflow_o,
  output logic [15:0]               pkt_sum_o
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM - 1);

  typedef enum logic [0:0] {COLLECT, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             handshake;
  logic             complete;
  logic             drop;
  logic [CNT_W-1:0] wr_slot;
  logic [CNT_W-1:0] fill_nxt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // An item arriving on the handshake edge opens the next packet in slot 0.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    handshake = 1'b0;
    complete  = 1'b0;
    drop      = 1'b0;
    wr_slot   = fill_o;
    fill_nxt  = fill_o;
    case (state)
      COLLECT: begin
        if (res_valid_i) begin
          accept   = 1'b1;
          fill_nxt = fill_o + CNT_W'(1);
          if (fill_o == LAST_SLOT) begin
            complete  = 1'b1;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (pkt_ready_i) begin
          handshake = 1'b1;
          state_nxt = COLLECT;
          wr_slot   = '0;
          fill_nxt  = '0;
          if (res_valid_i) begin
            accept   = 1'b1;
            fill_nxt = CNT_W'(1);
          end
        end else if (res_valid_i) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_o       <= '0;
      pkt_valid_o <= 1'b0;
      fill_o      <= '0;
      pkt_cnt_o   <= '0;
      overflow_o  <= 1'b0;
    end else begin
      fill_o      <= fill_nxt;
      pkt_valid_o <= (state_nxt == FULL);
      if (handshake) begin
        pkt_cnt_o <= pkt_cnt_o + 32'd1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
      for (int k = 0; k < NUM; k++) begin
        if (accept && (wr_slot == CNT_W'(k))) begin
          pkt_o[k*ITEM_WIDTH +: ITEM_WIDTH] <= res_i;
        end
      end
    end
  end

`ifdef RES_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] sum_nxt;

  assign sum_nxt = acc + 16'(res_i);

  // The accumulator is already zero on the handshake edge, so a coincident item starts it afresh.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc       <= '0;
      pkt_sum_o <= '0;
    end else if (accept) begin
      if (complete) begin
        pkt_sum_o <= sum_nxt;
        acc       <= '0;
      end else begin
        acc <= sum_nxt;
      end
    end
  end
`else
  assign pkt_sum_o = '0;
`endif

endmodule

// File: tb/tb_res_collector.sv
// tb/tb_res_collector.sv - scoreboard bench for res_collector (NUM=4 directed cases, NUM=100 streaming)
module tb_res_collector;

`ifdef RES_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // small instance
  logic        a_rst, a_rv, a_ready, a_valid, a_ovf;
  logic [7:0]  a_res;
  logic [31:0] a_pkt, a_cnt;
  logic [2:0]  a_fill;
  logic [15:0] a_sum;

  // streaming instance
  logic         b_rst, b_rv, b_ready, b_valid, b_ovf;
  logic [7:0]   b_res;
  logic [799:0] b_pkt;
  logic [31:0]  b_cnt;
  logic [6:0]   b_fill;
  logic [15:0]  b_sum;

  res_collector #(.NUM(4), .ITEM_WIDTH(8)) dut_a (
    .clk_i(clk), .reset_i(a_rst), .res_valid_i(a_rv), .res_i(a_res),
    .pkt_o(a_pkt), .pkt_valid_o(a_valid), .pkt_ready_i(a_ready),
    .fill_o(a_fill), .pkt_cnt_o(a_cnt), .overflow_o(a_ovf), .pkt_sum_o(a_sum)
  );

  res_collector #(.NUM(100), .ITEM_WIDTH(8)) dut_b (
    .clk_i(clk), .reset_i(b_rst), .res_valid_i(b_rv), .res_i(b_res),
    .pkt_o(b_pkt), .pkt_valid_o(b_valid), .pkt_ready_i(b_ready),
    .fill_o(b_fill), .pkt_cnt_o(b_cnt), .overflow_o(b_ovf), .pkt_sum_o(b_sum)
  );

  logic [31:0]  a_q[$];
  logic [15:0]  a_sq[$];
  logic [799:0] b_q[$];
  logic [15:0]  b_sq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: every handshake pops one expected packet
  always @(negedge clk) begin
    logic [31:0]  ea;
    logic [799:0] eb;
    logic [15:0]  es;
    if (a_valid && a_ready) begin
      total++;
      if (a_q.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_pkt got=%h exp=none", a_pkt);
      end else begin
        ea = a_q.pop_front();
        es = a_sq.pop_front();
        if (a_pkt !== ea) begin
          bad++;
          $display("FAIL a_pkt got=%h exp=%h", a_pkt, ea);
        end
        total++;
        if (a_sum !== es) begin
          bad++;
          $display("FAIL a_sum got=%h exp=%h", a_sum, es);
        end
      end
    end
    if (b_valid && b_ready) begin
      total++;
      if (b_q.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_pkt cnt=%0d exp=none", b_cnt);
      end else begin
        eb = b_q.pop_front();
        es = b_sq.pop_front();
        if (b_pkt !== eb) begin
          bad++;
          $display("FAIL b_pkt got=%h exp=%h", b_pkt, eb);
        end
        total++;
        if (b_sum !== es) begin
          bad++;
          $display("FAIL b_sum got=%h exp=%h", b_sum, es);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] v);
    a_rv  = 1'b1;
    a_res = v;
    tick();
    a_rv  = 1'b0;
  endtask

  task automatic pulse_ready_a();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic expect_a(input logic [31:0] p, input logic [15:0] s);
    a_q.push_back(p);
    a_sq.push_back(CK ? s : 16'h0);
  endtask

  initial begin
    logic [799:0] sp;
    a_rst = 1'b1; a_rv = 1'b0; a_res = '0; a_ready = 1'b0;
    b_rst = 1'b1; b_rv = 1'b0; b_res = '0; b_ready = 1'b0;
    repeat (3) tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    chk("rst_pkt", a_pkt, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_fill", a_fill, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_b_fill", b_fill, 0);

    // basic fill
    expect_a(32'h44332211, 16'h00AA);
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    chk("fill3_valid", a_valid, 0);
    chk("fill3_fill", a_fill, 3);
    send_a(8'h44);
    chk("full_valid", a_valid, 1);
    chk("full_fill", a_fill, 4);
    chk("full_pkt", a_pkt, 32'h44332211);

    // back-pressure drop
    send_a(8'h55);
    chk("bp_ovf", a_ovf, 1);
    chk("bp_pkt", a_pkt, 32'h44332211);
    chk("bp_fill", a_fill, 4);
    chk("bp_valid", a_valid, 1);
    pulse_ready_a();
    chk("hs_valid", a_valid, 0);
    chk("hs_cnt", a_cnt, 1);
    chk("hs_fill", a_fill, 0);
    chk("hs_ovf_sticky", a_ovf, 1);

    // coincident accept and handshake
    a_rst = 1'b1;
    #2;
    a_rst = 1'b0;
    tick();
    chk("rst2_ovf", a_ovf, 0);
    chk("rst2_cnt", a_cnt, 0);
    expect_a(32'hA4A3A2A1, 16'h028A);
    send_a(8'hA1);
    send_a(8'hA2);
    send_a(8'hA3);
    send_a(8'hA4);
    a_ready = 1'b1;
    a_rv    = 1'b1;
    a_res   = 8'h99;
    tick();
    a_ready = 1'b0;
    a_rv    = 1'b0;
    chk("co_cnt", a_cnt, 1);
    chk("co_fill", a_fill, 1);
    chk("co_slot0", a_pkt[7:0], 8'h99);
    chk("co_ovf", a_ovf, 0);
    chk("co_valid", a_valid, 0);
    expect_a(32'h9C9B9A99, 16'h026A);
    send_a(8'h9A);
    send_a(8'h9B);
    send_a(8'h9C);
    chk("co2_valid", a_valid, 1);
    pulse_ready_a();
    chk("co2_cnt", a_cnt, 2);

    // asynchronous reset mid-packet
    send_a(8'h01);
    send_a(8'h02);
    chk("mid_fill", a_fill, 2);
    #2;
    a_rst = 1'b1;
    #1;
    chk("mid_rst_fill", a_fill, 0);
    chk("mid_rst_pkt", a_pkt, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    #1;
    a_rst = 1'b0;
    tick();
    expect_a(32'hD4D3D2D1, 16'h034A);
    send_a(8'hD1);
    send_a(8'hD2);
    send_a(8'hD3);
    send_a(8'hD4);
    chk("mid_new_pkt", a_pkt, 32'hD4D3D2D1);
    pulse_ready_a();
    chk("mid_new_cnt", a_cnt, 1);

    // streaming, ready held high
    for (int k = 0; k < 100; k++) sp[k*8 +: 8] = 8'(k + 1);
    for (int p = 0; p < 5; p++) begin
      b_q.push_back(sp);
      b_sq.push_back(CK ? 16'h13BA : 16'h0);
    end
    b_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      for (int i = 1; i <= 100; i++) begin
        b_rv  = 1'b1;
        b_res = 8'(i);
        tick();
      end
    end
    b_rv = 1'b0;
    tick();
    tick();
    chk("stream_cnt", b_cnt, 5);
    chk("stream_ovf", b_ovf, 0);
    chk("stream_valid", b_valid, 0);
    chk("stream_fill", b_fill, 0);

    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
